// File: rtl/game_flow_ctrl_if.sv
// Button/event inputs and game-state outputs shared by the snake game flow controller.
interface game_flow_ctrl_if;
    logic       start_btn;
    logic       pause_btn;
    logic       collision;
    logic       good_collision;
    logic [1:0] mode;
    logic [1:0] state;
    logic [1:0] active_mode;
    logic       move_tick;
    logic [2:0] speed_level;
    logic       game_reset;

    modport master (
        output start_btn, pause_btn, collision, good_collision, mode,
        input  state, active_mode, move_tick, speed_level, game_reset
    );

    modport slave (
        input  start_btn, pause_btn, collision, good_collision, mode,
        output state, active_mode, move_tick, speed_level, game_reset
    );
endinterface

// File: rtl/game_flow_ctrl.sv
// Snake game sequencer: owns GAME_STATE, latches the game mode at start and
// generates the move strobe whose period shrinks as apples are eaten.
module game_flow_ctrl #(
    parameter int BASE_PERIOD      = 1000000,
    parameter int SPEED_STEP       = 100000,
    parameter int MAX_LEVEL        = 7,
    parameter int APPLES_PER_LEVEL = 4
) (
    input  logic             system_clk,
    input  logic             rst,
    game_flow_ctrl_if.slave  bus
);
    localparam int CNT_W = (BASE_PERIOD > 1) ? $clog2(BASE_PERIOD) : 1;
    localparam int AP_W  = $clog2(2 * APPLES_PER_LEVEL + 1);
    localparam logic [2:0] LVL_MAX = 3'(MAX_LEVEL);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        WAIT     = 2'b01,
        PAUSE    = 2'b10,
        END_GAME = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        TWO_APPLE     = 2'b00,
        NORMAL_MODE   = 2'b01,
        WALL_SPAWN    = 2'b10,
        BORDER_CHANGE = 2'b11
    } mode_t;

    state_t            state_q, state_d;
    mode_t             mode_q, mode_d;
    logic              tick_q, tick_d;
    logic [2:0]        level_q, level_d;
    logic              greset_q, greset_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [AP_W-1:0]   apple_q, apple_d;
    logic              start_q, pause_q;

    logic              start_rise, pause_rise;
    logic [31:0]       period;
    logic [AP_W-1:0]   thr;
    logic [AP_W-1:0]   apple_inc;

    assign start_rise = bus.start_btn & ~start_q;
    assign pause_rise = bus.pause_btn & ~pause_q;

    always_ff @(posedge system_clk or posedge rst) begin
        if (rst) begin
            state_q  <= WAIT;
            mode_q   <= NORMAL_MODE;
            tick_q   <= 1'b0;
            level_q  <= '0;
            greset_q <= 1'b0;
            cnt_q    <= '0;
            apple_q  <= '0;
            start_q  <= 1'b0;
            pause_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            tick_q   <= tick_d;
            level_q  <= level_d;
            greset_q <= greset_d;
            cnt_q    <= cnt_d;
            apple_q  <= apple_d;
            start_q  <= bus.start_btn;
            pause_q  <= bus.pause_btn;
        end
    end

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        tick_d    = 1'b0;
        level_d   = level_q;
        greset_d  = 1'b0;
        cnt_d     = cnt_q;
        apple_d   = apple_q;
        period    = 32'(BASE_PERIOD) - 32'(level_q) * 32'(SPEED_STEP);
        thr       = (mode_q == TWO_APPLE) ? AP_W'(2 * APPLES_PER_LEVEL)
                                          : AP_W'(APPLES_PER_LEVEL);
        apple_inc = apple_q + 1'b1;

        case (state_q)
            WAIT: begin
                cnt_d = '0;
                if (start_rise) begin
                    state_d  = RUN;
                    greset_d = 1'b1;
                    mode_d   = mode_t'(bus.mode);
                    level_d  = '0;
                    apple_d  = '0;
                end
            end
            RUN: begin
                if (bus.collision) begin
                    state_d = END_GAME;
                    cnt_d   = '0;
                end else begin
                    // Apples still count on the edge that enters PAUSE.
                    if (bus.good_collision && mode_q != BORDER_CHANGE) begin
                        if (apple_inc >= thr) begin
                            apple_d = '0;
                            if (level_q != LVL_MAX)
                                level_d = level_q + 1'b1;
                        end else begin
                            apple_d = apple_inc;
                        end
                    end
                    // >= so a level-up shortening the period mid-count still fires.
                    if (pause_rise)
                        state_d = PAUSE;
                    else if (32'(cnt_q) >= period - 32'd1) begin
                        cnt_d  = '0;
                        tick_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            PAUSE: begin
                if (pause_rise)
                    state_d = RUN;
            end
            END_GAME: begin
                cnt_d = '0;
                if (start_rise)
                    state_d = WAIT;
            end
            default: state_d = WAIT;
        endcase
    end

    assign bus.state       = state_q;
    assign bus.active_mode = mode_q;
    assign bus.move_tick   = tick_q;
    assign bus.speed_level = level_q;
    assign bus.game_reset  = greset_q;
endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: directed scenarios plus random play, all checked
// every cycle against an apple-count based reference model.
module tb_game_flow_ctrl;
    localparam int BP   = 10;
    localparam int SS   = 2;
    localparam int MAXL = 3;
    localparam int APL  = 2;

    logic system_clk = 1'b0;
    logic rst = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    game_flow_ctrl_if bus ();

    game_flow_ctrl #(
        .BASE_PERIOD(BP), .SPEED_STEP(SS), .MAX_LEVEL(MAXL), .APPLES_PER_LEVEL(APL)
    ) dut (
        .system_clk(system_clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 system_clk = ~system_clk;

    // Reference model: state codes 0=RUN 1=WAIT 2=PAUSE 3=END_GAME; speed level
    // is derived from the total apples eaten in the current game.
    int m_state, m_mode, m_cnt, m_apples;
    bit m_tick, m_greset, m_sq, m_pq;

    function automatic int exp_level(input int md, input int apples);
        int thr, lv;
        if (md == 3) return 0;
        thr = (md == 0) ? 2 * APL : APL;
        lv = apples / thr;
        return (lv > MAXL) ? MAXL : lv;
    endfunction

    always @(posedge system_clk or posedge rst) begin : model
        int period;
        bit sr, pr;
        if (rst) begin
            m_state <= 1; m_mode <= 1; m_cnt <= 0; m_apples <= 0;
            m_tick <= 0; m_greset <= 0; m_sq <= 0; m_pq <= 0;
        end else begin
            sr = bus.start_btn && !m_sq;
            pr = bus.pause_btn && !m_pq;
            period = BP - exp_level(m_mode, m_apples) * SS;
            m_sq <= bus.start_btn;
            m_pq <= bus.pause_btn;
            m_tick <= 0;
            m_greset <= 0;
            case (m_state)
                1: if (sr) begin
                    m_state <= 0; m_greset <= 1; m_mode <= int'(bus.mode);
                    m_apples <= 0; m_cnt <= 0;
                end
                0: if (bus.collision) begin
                    m_state <= 3; m_cnt <= 0;
                end else begin
                    if (bus.good_collision && m_mode != 3) m_apples <= m_apples + 1;
                    if (pr) m_state <= 2;
                    else if (m_cnt + 1 >= period) begin m_cnt <= 0; m_tick <= 1; end
                    else m_cnt <= m_cnt + 1;
                end
                2: if (pr) m_state <= 0;
                default: if (sr) m_state <= 1;
            endcase
        end
    end

    always @(negedge system_clk) begin
        int el;
        el = exp_level(m_mode, m_apples);
        vectors++;
        if (int'(bus.state) != m_state || int'(bus.active_mode) != m_mode ||
            bus.move_tick != m_tick || int'(bus.speed_level) != el ||
            bus.game_reset != m_greset) begin
            miscompares++;
            $display("FAIL model t=%0t: got st=%0d md=%0d tk=%0b lv=%0d gr=%0b, want st=%0d md=%0d tk=%0b lv=%0d gr=%0b",
                     $time, bus.state, bus.active_mode, bus.move_tick, bus.speed_level, bus.game_reset,
                     m_state, m_mode, m_tick, el, m_greset);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Cycles until the next move_tick, counted from the current negedge.
    task automatic next_tick(input int max, output int cyc);
        bit found;
        cyc = 0;
        found = 0;
        while (!found && cyc < max) begin
            @(negedge system_clk);
            cyc++;
            if (bus.move_tick) found = 1;
        end
        if (!found) check("tick_timeout", 0, 1);
    endtask

    task automatic apples(input int n);
        repeat (n) begin
            bus.good_collision = 1'b1;
            @(negedge system_clk);
            bus.good_collision = 1'b0;
            @(negedge system_clk);
        end
    endtask

    task automatic new_game(input logic [1:0] m);
        bus.collision = 1'b1;
        @(negedge system_clk);
        bus.collision = 1'b0;
        bus.start_btn = 1'b0;
        @(negedge system_clk);
        bus.start_btn = 1'b1;
        @(negedge system_clk);
        bus.start_btn = 1'b0;
        bus.mode = m;
        @(negedge system_clk);
        bus.start_btn = 1'b1;
        @(negedge system_clk);
    endtask

    initial begin
        int c, nt;
        bus.start_btn = 1'b0;
        bus.pause_btn = 1'b0;
        bus.collision = 1'b0;
        bus.good_collision = 1'b0;
        bus.mode = 2'b01;
        #1 rst = 1'b1;
        repeat (2) @(negedge system_clk);
        rst = 1'b0;
        @(negedge system_clk);
        check("reset_state", bus.state, 1);
        check("reset_mode", bus.active_mode, 1);
        check("reset_level", bus.speed_level, 0);

        // Start and base tick period; start held high afterwards
        bus.start_btn = 1'b1;
        @(negedge system_clk);
        check("start_state", bus.state, 0);
        check("start_greset", bus.game_reset, 1);
        next_tick(20, c);
        check("first_tick_latency", c, 10);
        check("greset_single", bus.game_reset, 0);
        next_tick(20, c);
        check("tick_spacing_l0", c, 10);
        check("start_held_state", bus.state, 0);

        // Speed ramp
        apples(2);
        check("level_after_2", bus.speed_level, 1);
        next_tick(20, c);
        next_tick(20, c);
        check("tick_spacing_l1", c, 8);
        apples(6);
        check("level_after_8", bus.speed_level, 3);
        next_tick(20, c);
        next_tick(20, c);
        check("tick_spacing_l3", c, 4);
        apples(2);
        check("level_saturated", bus.speed_level, 3);

        // Pause right after a tick, start ignored while paused
        next_tick(20, c);
        bus.pause_btn = 1'b1;
        @(negedge system_clk);
        check("pause_state", bus.state, 2);
        nt = 0;
        for (int i = 0; i < 30; i++) begin
            if (i == 10) bus.start_btn = 1'b0;
            if (i == 12) bus.start_btn = 1'b1;
            @(negedge system_clk);
            if (bus.move_tick) nt++;
        end
        check("pause_no_ticks", nt, 0);
        check("pause_start_ignored", bus.state, 2);
        bus.pause_btn = 1'b0;
        @(negedge system_clk);
        bus.pause_btn = 1'b1;
        @(negedge system_clk);
        check("resume_state", bus.state, 0);
        next_tick(20, c);
        check("resume_tick_latency", c, 4);

        // Collision beats pause and apple
        bus.pause_btn = 1'b0;
        @(negedge system_clk);
        bus.collision = 1'b1;
        bus.good_collision = 1'b1;
        bus.pause_btn = 1'b1;
        @(negedge system_clk);
        bus.collision = 1'b0;
        bus.good_collision = 1'b0;
        bus.pause_btn = 1'b0;
        check("end_state", bus.state, 3);
        check("end_level_kept", bus.speed_level, 3);
        check("end_no_tick", bus.move_tick, 0);
        bus.start_btn = 1'b0;
        @(negedge system_clk);
        bus.start_btn = 1'b1;
        @(negedge system_clk);
        check("end_to_wait", bus.state, 1);
        bus.start_btn = 1'b0;
        @(negedge system_clk);
        bus.start_btn = 1'b1;
        @(negedge system_clk);
        check("restart_state", bus.state, 0);
        check("restart_level", bus.speed_level, 0);
        check("restart_greset", bus.game_reset, 1);

        // Mode-dependent thresholds
        new_game(2'b00);
        check("two_apple_mode", bus.active_mode, 0);
        apples(2);
        check("two_apple_lv_2", bus.speed_level, 0);
        apples(2);
        check("two_apple_lv_4", bus.speed_level, 1);
        new_game(2'b11);
        apples(8);
        check("border_lv", bus.speed_level, 0);
        bus.mode = 2'b01;
        repeat (3) @(negedge system_clk);
        check("mode_latched", bus.active_mode, 3);

        // Async reset between edges, right as move_tick is high
        new_game(2'b01);
        apples(2);
        next_tick(20, c);
        #2 rst = 1'b1;
        #1;
        check("async_state", bus.state, 1);
        check("async_tick", bus.move_tick, 0);
        check("async_level", bus.speed_level, 0);
        check("async_greset", bus.game_reset, 0);
        bus.start_btn = 1'b0;
        repeat (2) @(negedge system_clk);
        rst = 1'b0;
        @(negedge system_clk);
        bus.start_btn = 1'b1;
        @(negedge system_clk);
        check("post_reset_state", bus.state, 0);
        check("post_reset_greset", bus.game_reset, 1);
        next_tick(20, c);
        check("post_reset_tick", c, 10);

        // Random play, checked by the model every cycle
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(19) == 0) bus.start_btn = ~bus.start_btn;
            if ($urandom_range(14) == 0) bus.pause_btn = ~bus.pause_btn;
            bus.collision = ($urandom_range(249) == 0);
            bus.good_collision = ($urandom_range(5) == 0);
            bus.mode = 2'($urandom_range(3));
            @(negedge system_clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
